// File: rtl/sdm_dac_if.sv
// Sample input handshake for the sigma-delta DAC.
// The producer drives data/valid; the DAC answers with ready.
interface sdm_dac_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/sdm_dac.sv
// First-order sigma-delta DAC fed by a small sample FIFO.
// One sample is consumed every OSR clocks; empty loads flag underrun.
module sdm_dac #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OSR   = 32
) (
    input  logic                   clk,
    input  logic                   reset_in,
    input  logic                   en,
    sdm_dac_if.slave               bus,
    output logic                   dac_out,
    output logic                   sample_strobe,
    output logic                   underrun,
    input  logic                   underrun_clr,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [PW-1:0] PHASE_MAX = PW'(OSR - 1);
    localparam logic [PW-1:0] PHASE_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [PW-1:0]    phase;
    logic [WIDTH-1:0] cur_sample;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic             empty;
    logic             push;
    logic             load;
    logic             pop;

    // Ready depends on occupancy only, so a full FIFO refuses a
    // push even on the cycle it pops.
    assign bus.in_ready = (fifo_level != FULL);
    assign empty        = (fifo_level == '0);
    assign push         = bus.in_valid && bus.in_ready;
    assign load         = en && (phase == '0);
    assign pop          = load && !empty;
    assign sum          = {1'b0, acc} + {1'b0, cur_sample};

    // Sample storage; contents are don't-care while level is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sample-period counter; zero marks a load attempt, so the
    // first enabled cycle always loads.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            phase <= '0;
        end else if (!en) begin
            phase <= '0;
        end else if (phase == '0) begin
            phase <= PHASE_MAX;
        end else begin
            phase <= phase - PHASE_ONE;
        end
    end

    // Current sample register; an empty load keeps the last value.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            cur_sample <= '0;
        end else if (pop) begin
            cur_sample <= mem[rd_ptr];
        end
    end

    // First-order modulator: the accumulator carry is the output bit.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            acc           <= '0;
            dac_out       <= 1'b0;
            sample_strobe <= 1'b0;
        end else if (!en) begin
            acc           <= '0;
            dac_out       <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            acc           <= sum[WIDTH-1:0];
            dac_out       <= sum[WIDTH];
            sample_strobe <= load;
        end
    end

    // Sticky underrun; a new empty load beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            underrun <= 1'b0;
        end else if (load && empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdm_dac.sv
// Directed bench for sdm_dac: vector table plus multi-cycle sequences.
// A second instance with OSR=256 covers the full-scale extremes.
module tb_sdm_dac;
    logic clk = 1'b0;
    logic reset_in;

    logic en_a, clr_a, dac_a, strobe_a, ur_a;
    logic [2:0] level_a;
    logic en_b, clr_b, dac_b, strobe_b, ur_b;
    logic [2:0] level_b;

    int checks = 0;
    int errors = 0;

    sdm_dac_if #(.WIDTH(8)) bus_a ();
    sdm_dac_if #(.WIDTH(8)) bus_b ();

    sdm_dac #(.WIDTH(8), .DEPTH(4), .OSR(32)) u_dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .en            (en_a),
        .bus           (bus_a.slave),
        .dac_out       (dac_a),
        .sample_strobe (strobe_a),
        .underrun      (ur_a),
        .underrun_clr  (clr_a),
        .fifo_level    (level_a)
    );

    sdm_dac #(.WIDTH(8), .DEPTH(4), .OSR(256)) u_big (
        .clk           (clk),
        .reset_in      (reset_in),
        .en            (en_b),
        .bus           (bus_b.slave),
        .dac_out       (dac_b),
        .sample_strobe (strobe_b),
        .underrun      (ur_b),
        .underrun_clr  (clr_b),
        .fifo_level    (level_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [7:0] data;
        logic       en;
        int         level;
        logic       ready;
        logic       strobe;
        logic       ur;
        logic       dac;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, output int ones_a, output int ones_b);
        ones_a = 0;
        ones_b = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            ones_a += int'(dac_a);
            ones_b += int'(dac_b);
        end
    endtask

    task automatic do_reset();
        en_a           = 1'b0;
        en_b           = 1'b0;
        clr_a          = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        reset_in       = 1'b0;
        tick();
        reset_in = 1'b1;
    endtask

    task automatic push_a(input logic [7:0] d);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        tick();
        bus_a.in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = d;
        tick();
        bus_b.in_valid = 1'b0;
    endtask

    initial begin
        int oa, ob, bad, ones, early;

        vecs[0] = '{"push11", 1, 8'h11, 0, 1, 1, 0, 0, 0};
        vecs[1] = '{"push22", 1, 8'h22, 0, 2, 1, 0, 0, 0};
        vecs[2] = '{"push33", 1, 8'h33, 0, 3, 1, 0, 0, 0};
        vecs[3] = '{"push44", 1, 8'h44, 0, 4, 0, 0, 0, 0};
        vecs[4] = '{"refuse", 1, 8'h55, 0, 4, 0, 0, 0, 0};
        vecs[5] = '{"idle",   0, 8'h00, 0, 4, 0, 0, 0, 0};
        vecs[6] = '{"colpop", 1, 8'h55, 1, 3, 1, 1, 0, 0};
        vecs[7] = '{"colpsh", 1, 8'h55, 1, 4, 0, 0, 0, 0};
        vecs[8] = '{"endis",  0, 8'h00, 0, 4, 0, 0, 0, 0};

        reset_in       = 1'b0;
        en_a           = 1'b0;
        en_b           = 1'b0;
        clr_a          = 1'b0;
        clr_b          = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = '0;
        tick();
        chk("rst_level", level_a, 0);
        chk("rst_ready", bus_a.in_ready, 1);
        chk("rst_dac", dac_a, 0);
        chk("rst_strobe", strobe_a, 0);
        chk("rst_ur", ur_a, 0);
        reset_in = 1'b1;

        for (int i = 0; i < 9; i++) begin
            bus_a.in_valid = vecs[i].valid;
            bus_a.in_data  = vecs[i].data;
            en_a           = vecs[i].en;
            tick();
            chk({vecs[i].name, "_level"}, level_a, vecs[i].level);
            chk({vecs[i].name, "_ready"}, bus_a.in_ready, vecs[i].ready);
            chk({vecs[i].name, "_strobe"}, strobe_a, vecs[i].strobe);
            chk({vecs[i].name, "_ur"}, ur_a, vecs[i].ur);
            chk({vecs[i].name, "_dac"}, dac_a, vecs[i].dac);
        end
        bus_a.in_valid = 1'b0;

        // Midscale 0x80
        do_reset();
        push_a(8'h80);
        chk("mid_level", level_a, 1);
        en_a = 1'b1;
        tick();
        chk("mid_strobe1", strobe_a, 1);
        chk("mid_pop", level_a, 0);
        bad = 0;
        ones = 0;
        early = 0;
        for (int k = 2; k <= 33; k++) begin
            tick();
            ones += int'(dac_a);
            if (int'(dac_a) != (k % 2)) bad++;
            if (k < 33 && ur_a) early++;
            if (k == 2) chk("mid_strobe2", strobe_a, 0);
        end
        chk("mid_alt", bad, 0);
        chk("mid_ones", ones, 16);
        chk("mid_ur_early", early, 0);
        chk("mid_ur33", ur_a, 1);
        chk("mid_strobe33", strobe_a, 1);

        // Ordering, held sample, underrun clear and set-wins
        do_reset();
        push_a(8'h40);
        push_a(8'hC0);
        chk("ord_level", level_a, 2);
        en_a = 1'b1;
        tick();
        chk("ord_strobe1", strobe_a, 1);
        run(32, oa, ob);
        chk("ord_ones40", oa, 8);
        chk("ord_strobe33", strobe_a, 1);
        chk("ord_ur33", ur_a, 0);
        chk("ord_level33", level_a, 0);
        run(32, oa, ob);
        chk("ord_onesC0", oa, 24);
        chk("ord_ur65", ur_a, 1);
        run(32, oa, ob);
        chk("ord_held", oa, 24);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("ord_clr", ur_a, 0);
        run(30, oa, ob);
        chk("ord_ur_quiet", ur_a, 0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("ord_setwins", ur_a, 1);
        en_a = 1'b0;

        // Extremes with OSR=256
        do_reset();
        push_b(8'h00);
        push_b(8'hFF);
        chk("ext_level", level_b, 2);
        en_b = 1'b1;
        tick();
        chk("ext_strobe1", strobe_b, 1);
        run(256, oa, ob);
        chk("ext_zero", ob, 0);
        chk("ext_strobe257", strobe_b, 1);
        chk("ext_level257", level_b, 0);
        chk("ext_ur257", ur_b, 0);
        run(256, oa, ob);
        chk("ext_full", ob, 255);
        en_b = 1'b0;

        // Reset mid-period
        do_reset();
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        en_a = 1'b1;
        tick();
        run(21, oa, ob);
        chk("mrst_level", level_a, 2);
        reset_in = 1'b0;
        #1;
        chk("mrst_level0", level_a, 0);
        chk("mrst_dac", dac_a, 0);
        chk("mrst_strobe", strobe_a, 0);
        chk("mrst_ur", ur_a, 0);
        @(negedge clk);
        reset_in = 1'b1;
        tick();
        chk("mrst_ur_after", ur_a, 1);
        chk("mrst_strobe_after", strobe_a, 1);
        chk("mrst_level_after", level_a, 0);
        en_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdm_dac.md
Name: sdm_dac

Overview:
- Output-direction companion to the SAR ADC path: converts buffered 8-bit digital samples into a 1-bit first-order sigma-delta bitstream that drives an external RC filter pin.
- Samples enter through a valid/ready handshake into a small FIFO.
- Samples are consumed at a fixed rate of one every OSR clocks (5 MHz clk, OSR=32 gives 156.25 kS/s).
- Underrun is flagged and held until cleared.

Parameters:
WIDTH, 8, sample width in bits; accumulator width
DEPTH, 4, FIFO depth in samples (power of 2, >=2)
OSR, 32, clocks per sample period (>=2)

Ports:
clk  input  1  system clock
reset_in  input  1  asynchronous, active-low reset
en  input  1  modulator enable; FIFO input accepted regardless of en
in_data  input  WIDTH  sample to enqueue
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept; = (level != DEPTH)
dac_out  output  1  registered sigma-delta bitstream
sample_strobe  output  1  one-cycle pulse, cycle after each sample load attempt
underrun  output  1  sticky: load attempted with FIFO empty
underrun_clr  input  1  synchronous clear of underrun
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, reset_in=0):
  - FIFO pointers and level = 0.
  - cur_sample = 0, acc = 0, phase = 0.
  - dac_out = 0, sample_strobe = 0, underrun = 0.
- Push: occurs on a clock edge with in_valid && in_ready. in_ready depends only on level, so a full FIFO refuses a push even in the cycle it pops.
- Simultaneous push and pop: level unchanged; data ordering is FIFO.
- Phase counter, only when en=1:
  - phase==0: load attempt; phase <= OSR-1.
  - otherwise: phase <= phase-1.
  - The first enabled cycle after reset or after en falls is therefore a load attempt.
- Load attempt:
  - FIFO non-empty: pop head into cur_sample.
  - FIFO empty: cur_sample holds its previous value and underrun <= 1.
  - Either case: sample_strobe = 1 on the following cycle.
- Modulator, each enabled clock:
  - sum = {1'b0,acc} + {1'b0,cur_sample}, WIDTH+1 bits.
  - acc <= sum[WIDTH-1:0]; dac_out <= sum[WIDTH].
  - Uses the cur_sample value before that edge, so a newly loaded sample affects dac_out from the second clock after load.
  - Ones density = cur_sample / 2^WIDTH; 0x00 gives a constant 0; 0xFF gives one 0 per 256 clocks.
- en=0, synchronous:
  - phase <= 0, acc <= 0, dac_out <= 0, sample_strobe <= 0.
  - cur_sample and FIFO contents retained; pushes continue.
- underrun_clr=1: underrun <= 0.
  - If a load attempt on an empty FIFO coincides with the clear, the set wins.
- Reset mid-operation: all state, including FIFO contents, is discarded immediately. No partial sample period completes.
- Wrap-around: FIFO pointers wrap modulo DEPTH. The acc carry is discarded into dac_out only; acc never saturates.

Test Plan:
- Fill: en=0, push 0x11,0x22,0x33,0x44 -> fifo_level=4, in_ready=0; a 5th in_valid is not accepted and level stays 4.
- Midscale: push 0x80, en=1 -> strobe on cycle 2; from cycle 3 dac_out alternates 0,1; exactly 16 ones in every 32-clock window; underrun set at the 2nd load attempt (clock 33).
- Extremes:
  - Push 0x00 then 0xFF with OSR=256 override -> first period dac_out all 0.
  - Second period: exactly 255 ones in 256 clocks (excluding the 1-clock load latency).
- Ordering/underrun: push 0x40,0xC0, en=1 -> loaded in order, densities 1/4 then 3/4.
  - Third load attempt sets underrun=1; 0xC0 is held and density stays 3/4.
  - underrun_clr pulse -> underrun=0 next cycle.
- Pop/push collision: FIFO full, assert in_valid through a load attempt -> no push that cycle; level 4->3; push accepted next cycle, level back to 4.
- Reset mid-period:
  - Drop reset_in at phase=10 with level=2 -> outputs and level 0 immediately, underrun=0.
  - After release with en=1, the first enabled cycle is a load attempt on an empty FIFO -> underrun=1.
